// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: drives the data-memory request/grant/response bus and extends load data.
// Latency: store 2 cycles (req->done), load 3 cycles, +1 per grant wait and per rvalid wait; faults in 1.
// Backpressure: holds mem_req and its payload until mem_gnt; stalls the core until done or fault.
//
// Ports: clk/rstn (async active-low); req_* from the core (held until done/fault);
// stall/done/fault/rd_data back to the core; mem_* request/grant/response to the data bus.
module lsu_mem_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output logic [31:0] rd_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;

    logic        funct_ok;
    logic        aligned;
    logic [3:0]  strb_base;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] lane;
    logic [31:0] ld_ext;

    // Request decode: legality, alignment, strobe and replicated store data.
    always_comb begin
        funct_ok  = 1'b0;
        aligned   = 1'b1;
        strb_base = 4'b0001;
        wdata_d   = {4{req_wdata[7:0]}};
        if (req_we)
            funct_ok = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
        else
            funct_ok = (req_funct3 != 3'b011) && (req_funct3[2:1] != 2'b11);
        case (req_funct3[1:0])
            2'b00: begin
                aligned   = 1'b1;
                strb_base = 4'b0001;
                wdata_d   = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                aligned   = ~req_addr[0];
                strb_base = 4'b0011;
                wdata_d   = {2{req_wdata[15:0]}};
            end
            default: begin
                aligned   = (req_addr[1:0] == 2'b00);
                strb_base = 4'b1111;
                wdata_d   = req_wdata;
            end
        endcase
        // Loads never assert strobes; the shift is only reached with aligned offsets.
        wstrb_d = req_we ? 4'(strb_base << req_addr[1:0]) : 4'b0000;
    end

    // Load extraction: move the addressed lane to bit 0, then extend by funct3.
    always_comb begin
        lane   = mem_rdata >> {off_q, 3'b000};
        ld_ext = lane;
        case (f3_q)
            3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {24'h0, lane[7:0]};
            3'b101:  ld_ext = {16'h0, lane[15:0]};
            default: ld_ext = lane;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid)
                    state_nxt = (funct_ok && aligned) ? S_REQ : S_ERR;
            end
            S_REQ: begin
                if (mem_gnt)
                    state_nxt = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid)
                    state_nxt = S_DONE;
            end
            // DONE/ERR ignore req_valid: it still belongs to the finishing instruction.
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            addr_q  <= 32'h0;
            wstrb_q <= 4'h0;
            wdata_q <= 32'h0;
            rd_data <= 32'h0;
        end else begin
            if (state == S_IDLE && req_valid && funct_ok && aligned) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                off_q   <= req_addr[1:0];
                addr_q  <= {req_addr[31:2], 2'b00};
                wstrb_q <= wstrb_d;
                wdata_q <= wdata_d;
            end
            if (state == S_WAIT && mem_rvalid)
                rd_data <= ld_ext;
        end
    end

    assign mem_req   = (state == S_REQ);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_wstrb = wstrb_q;
    assign mem_wdata = wdata_q;
    assign done      = (state == S_DONE);
    assign fault     = (state == S_ERR);
    assign stall     = req_valid & ~done & ~fault;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed accesses with a cycle-level expectation timeline.
// Latency: n/a (testbench).
// Backpressure: bus grant and rvalid delays are driven per access.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, done, fault;
    logic [31:0] rd_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    lsu_mem_ctrl dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .fault(fault), .rd_data(rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0 = 0;
    int done_cyc = -1;
    logic chk_en = 1'b0;
    logic req_seen = 1'b0;
    logic [3:0]  seen_wstrb = 4'h0;
    logic [31:0] seen_wdata = 32'h0;
    logic [31:0] seen_addr  = 32'h0;

    // Expected outputs for the current cycle.
    logic        exp_stall = 0, exp_done = 0, exp_fault = 0, exp_req = 0, exp_we = 0;
    logic [31:0] exp_addr = 0, exp_wdata = 0, exp_rd = 0;
    logic [3:0]  exp_wstrb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic ok;
        if (we) ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        else    ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return ok && ((a % m_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [31:0] a);
        int bits;
        bits = (1 << m_size(f3)) - 1;
        return 4'(bits << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        if (m_size(f3) == 1) r = d[7:0] * 32'h0101_0101;
        else if (m_size(f3) == 2) r = d[15:0] * 32'h0001_0001;
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        int sz;
        sz = m_size(f3);
        v = w >> (8 * (a % 4));
        if (sz < 4) begin
            v = v & ((32'h1 << (8 * sz)) - 1);
            if (!f3[2] && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 1);
        end
        return v;
    endfunction

    // ---------------- compare / monitor ----------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", stall, exp_stall);
            chk("done", done, exp_done);
            chk("fault", fault, exp_fault);
            chk("mem_req", mem_req, exp_req);
            chk("mem_we", mem_we, exp_req & exp_we);
            chk("rd_data", rd_data, exp_rd);
            if (exp_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_wstrb", mem_wstrb, exp_wstrb);
                if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
            end
        end
        if (mem_req) begin
            req_seen   = 1'b1;
            seen_wstrb = mem_wstrb;
            seen_wdata = mem_wdata;
            seen_addr  = mem_addr;
        end
        if (done) done_cyc = cyc;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gw, input int rw,
                          input logic [31:0] rdat);
        step();
        t0 = cyc;
        req_seen = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_stall = 1'b1; exp_done = 1'b0; exp_fault = 1'b0; exp_req = 1'b0;
        if (!m_legal(we, f3, a)) begin
            step();
            exp_stall = 1'b0; exp_fault = 1'b1;
            step();
            req_valid = 1'b0; exp_fault = 1'b0;
        end else begin
            exp_we    = we;
            exp_addr  = {a[31:2], 2'b00};
            exp_wstrb = we ? m_strb(f3, a) : 4'h0;
            exp_wdata = m_wdata(f3, wd);
            for (int i = 0; i <= gw; i++) begin
                step();
                exp_req = 1'b1;
                mem_gnt = (i == gw);
            end
            step();
            mem_gnt = 1'b0; exp_req = 1'b0;
            if (!we) begin
                for (int i = 0; i <= rw; i++) begin
                    if (i > 0) step();
                    mem_rvalid = (i == rw);
                    mem_rdata  = (i == rw) ? rdat : 32'hDEAD_BEEF;
                end
                step();
                mem_rvalid = 1'b0;
                exp_rd = m_load(f3, a, rdat);
            end
            exp_done = 1'b1; exp_stall = 1'b0;
            step();
            req_valid = 1'b0; exp_done = 1'b0;
        end
    endtask

    initial begin
        rstn = 1'b0;
        req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        #12;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wstrb", mem_wstrb, 0);
        step();
        rstn = 1'b1;
        chk_en = 1'b1;

        // SB at 0x1003: strobe on the top lane, byte replicated, done 2 cycles after request.
        access(1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, 0);
        chk("sb_wstrb_lit", seen_wstrb, 4'b1000);
        chk("sb_wdata_lit", seen_wdata, 32'hA5A5_A5A5);
        chk("sb_addr_lit", seen_addr, 32'h0000_1000);
        chk("sb_done_cyc", done_cyc - t0, 2);

        access(0, 3'b000, 32'h0000_2001, 0, 0, 0, 32'h1234_80FF);      // LB
        chk("lb_lit", rd_data, 32'hFFFF_FF80);
        chk("lb_done_cyc", done_cyc - t0, 3);
        access(0, 3'b100, 32'h0000_2001, 0, 0, 0, 32'h1234_80FF);      // LBU
        chk("lbu_lit", rd_data, 32'h0000_0080);
        access(0, 3'b101, 32'h0000_2002, 0, 0, 0, 32'h1234_80FF);      // LHU
        chk("lhu_lit", rd_data, 32'h0000_1234);
        access(0, 3'b001, 32'h0000_2002, 0, 1, 0, 32'h8001_0000);      // LH, sign
        chk("lh_lit", rd_data, 32'hFFFF_8001);
        access(1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 1, 0, 0);      // SH upper half
        chk("sh_wstrb_lit", seen_wstrb, 4'b1100);
        chk("sh_wdata_lit", seen_wdata, 32'hBEEF_BEEF);
        access(1, 3'b010, 32'h0000_2004, 32'h0BAD_CAFE, 0, 0, 0);      // SW
        chk("sw_wstrb_lit", seen_wstrb, 4'b1111);

        // Faults: no bus request, rd_data untouched.
        access(0, 3'b010, 32'h0000_3002, 0, 0, 0, 0);                  // LW misaligned
        chk("lw_mis_noreq", req_seen, 0);
        chk("lw_mis_rd_hold", rd_data, 32'hFFFF_8001);
        access(1, 3'b001, 32'h0000_3001, 32'h1111, 0, 0, 0);           // SH misaligned
        chk("sh_mis_noreq", req_seen, 0);
        access(0, 3'b011, 32'h0000_3000, 0, 0, 0, 0);                  // illegal load
        access(1, 3'b100, 32'h0000_3000, 0, 0, 0, 0);                  // illegal store
        chk("st_ill_noreq", req_seen, 0);

        // LW with grant in cycle 4 and rvalid in cycle 6: done in cycle 7.
        access(0, 3'b010, 32'h0000_3000, 0, 3, 1, 32'hCAFE_F00D);
        chk("lw_slow_lit", rd_data, 32'hCAFE_F00D);
        chk("lw_slow_done_cyc", done_cyc - t0, 7);

        // Reset in WAIT: outputs clear asynchronously, late rvalid ignored.
        step();
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h0000_4000;
        exp_stall = 1;
        step();
        exp_req = 1; exp_we = 0; exp_addr = 32'h0000_4000; exp_wstrb = 0;
        mem_gnt = 1;
        step();
        mem_gnt = 0; exp_req = 0;
        #2;
        rstn = 1'b0;
        req_valid = 1'b0;
        exp_stall = 0; exp_rd = 0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_done", done, 0);
        chk("arst_stall", stall, 0);
        chk("arst_rd_data", rd_data, 0);
        chk("arst_mem_addr", mem_addr, 0);
        step();
        rstn = 1'b1;
        step();
        mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        step();
        mem_rvalid = 0;
        step();
        chk("stray_rd_data", rd_data, 0);
        access(1, 3'b010, 32'h0000_5008, 32'h8765_4321, 0, 0, 0);
        chk("sw_after_rst_wdata", seen_wdata, 32'h8765_4321);
        chk("sw_after_rst_done", done_cyc - t0, 2);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
